// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Producer end of the common data bus. Each functional unit drops its
//   completed results into a small private FIFO; a round-robin arbiter
//   moves one FIFO head per cycle onto the registered CDB outputs that feed
//   the reservation stations and the ROB.
//
// Ports
//   clk_in          clock, all state changes on the rising edge
//   rst_in          asynchronous active-low reset
//   flush_in        synchronous clear of all buffered results (mispredict)
//   fu_valid_in     [NUM_FU]       unit k offers a result
//   fu_rob_ix_in    [NUM_FU*3]     ROB index of unit k's result
//   fu_value_in     [NUM_FU*32]    result value of unit k (signed)
//   fu_dest_in      [NUM_FU*32]    destination/target of unit k (signed)
//   fu_stall_out    [NUM_FU]       unit k's FIFO is full
//   cdb_valid_out   CDB carries a result this cycle (one-cycle pulse)
//   cdb_rob_ix_out  broadcast ROB index
//   cdb_value_out   broadcast value
//   cdb_dest_out    broadcast destination/target
//
// Handshake: a result on unit k transfers at a rising edge when
// fu_valid_in[k]=1 and fu_stall_out[k]=0 (stall is the inverted ready) and
// flush_in=0. While stalled the unit must keep the same result presented.
// fu_stall_out depends only on registered FIFO occupancy, never on inputs.
module cdb_arbiter #(
   parameter int NUM_FU     = 3,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       flush_in,
   input  logic [NUM_FU-1:0]          fu_valid_in,
   input  logic [NUM_FU*3-1:0]        fu_rob_ix_in,
   input  logic signed [NUM_FU*32-1:0] fu_value_in,
   input  logic signed [NUM_FU*32-1:0] fu_dest_in,
   output logic [NUM_FU-1:0]          fu_stall_out,
   output logic                       cdb_valid_out,
   output logic [2:0]                 cdb_rob_ix_out,
   output logic signed [31:0]         cdb_value_out,
   output logic signed [31:0]         cdb_dest_out
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int IW = $clog2(NUM_FU);

   logic [2:0]         mem_rob   [NUM_FU][FIFO_DEPTH];
   logic signed [31:0] mem_value [NUM_FU][FIFO_DEPTH];
   logic signed [31:0] mem_dest  [NUM_FU][FIFO_DEPTH];

   logic [PW-1:0] head  [NUM_FU];
   logic [PW-1:0] tail  [NUM_FU];
   logic [CW-1:0] count [NUM_FU];

   logic [IW-1:0]     rr_ptr;
   logic [IW-1:0]     win_ix;
   logic [IW-1:0]     rr_next;
   logic              win_found;
   logic [NUM_FU-1:0] cand;
   logic [NUM_FU-1:0] full;
   logic [NUM_FU-1:0] push;
   logic [NUM_FU-1:0] pop;

   // Per-unit occupancy decode. A full FIFO refuses a push even if its head
   // pops on the same edge, so the stall never depends on the arbiter.
   always_comb begin
      cand = '0;
      full = '0;
      push = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         cand[k] = (count[k] != '0);
         full[k] = (count[k] == CW'(FIFO_DEPTH));
         push[k] = fu_valid_in[k] && !full[k] && !flush_in;
      end
   end

   assign fu_stall_out = full;

   // Round-robin search starting at rr_ptr; only entries already stored
   // compete, so a result pushed this edge is never broadcast this edge.
   always_comb begin
      logic [IW:0]   sum;
      logic [IW-1:0] idx;
      sum       = '0;
      idx       = '0;
      win_found = 1'b0;
      win_ix    = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         sum = {1'b0, rr_ptr} + (IW+1)'(i);
         if (sum >= (IW+1)'(NUM_FU)) begin
            sum = sum - (IW+1)'(NUM_FU);
         end
         idx = sum[IW-1:0];
         if (!win_found && cand[idx]) begin
            win_found = 1'b1;
            win_ix    = idx;
         end
      end
   end

   always_comb begin
      pop = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         pop[k] = win_found && !flush_in && (win_ix == IW'(k));
      end
      rr_next = (win_ix == IW'(NUM_FU - 1)) ? '0 : win_ix + 1'b1;
   end

   // Result storage carries no reset; occupancy alone decides validity.
   always_ff @(posedge clk_in) begin
      for (int k = 0; k < NUM_FU; k++) begin
         if (push[k]) begin
            mem_rob[k][tail[k]]   <= fu_rob_ix_in[k*3 +: 3];
            mem_value[k][tail[k]] <= fu_value_in[k*32 +: 32];
            mem_dest[k][tail[k]]  <= fu_dest_in[k*32 +: 32];
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int k = 0; k < NUM_FU; k++) begin
            head[k]  <= '0;
            tail[k]  <= '0;
            count[k] <= '0;
         end
         rr_ptr         <= '0;
         cdb_valid_out  <= 1'b0;
         cdb_rob_ix_out <= '0;
         cdb_value_out  <= '0;
         cdb_dest_out   <= '0;
      end else begin
         cdb_valid_out <= 1'b0;
         if (flush_in) begin
            // Drop everything buffered; rr_ptr and CDB data keep their values.
            for (int k = 0; k < NUM_FU; k++) begin
               head[k]  <= '0;
               tail[k]  <= '0;
               count[k] <= '0;
            end
         end else begin
            for (int k = 0; k < NUM_FU; k++) begin
               if (push[k]) begin
                  tail[k] <= tail[k] + 1'b1;
               end
               if (pop[k]) begin
                  head[k] <= head[k] + 1'b1;
               end
               if (push[k] && !pop[k]) begin
                  count[k] <= count[k] + 1'b1;
               end else if (pop[k] && !push[k]) begin
                  count[k] <= count[k] - 1'b1;
               end
            end
            if (win_found) begin
               cdb_valid_out  <= 1'b1;
               cdb_rob_ix_out <= mem_rob[win_ix][head[win_ix]];
               cdb_value_out  <= mem_value[win_ix][head[win_ix]];
               cdb_dest_out   <= mem_dest[win_ix][head[win_ix]];
               rr_ptr         <= rr_next;
            end
         end
      end
   end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Producer end of the common data bus. Collects completed results from NUM_FU functional units into small per-unit FIFOs. Round-robin arbitrates one result per cycle onto the CDB, whose outputs feed every reservation station's CDB inputs and the ROB. Asserts per-unit stall when a unit's FIFO is full.

## Interface
- NUM_FU, 3: number of functional-unit result ports (≥2)
- FIFO_DEPTH, 2: entries per unit FIFO (power of two, ≥2)
- clk_in  input  1  clock; all state changes on rising edge
- rst_in  input  1  reset, asynchronous, active-low (0 = reset)
- flush_in  input  1  synchronous clear of all buffered results (mispredict)
- fu_valid_in  input  NUM_FU  result offered by unit k
- fu_rob_ix_in  input  NUM_FU×3  ROB index of unit k's result
- fu_value_in  input  NUM_FU×32 signed  result value of unit k
- fu_dest_in  input  NUM_FU×32 signed  auxiliary destination/target of unit k
- fu_stall_out  output  NUM_FU  unit k's FIFO full; offered result not accepted
- cdb_valid_out  output  1  CDB carries a result this cycle
- cdb_rob_ix_out  output  3  broadcast ROB index
- cdb_value_out  output  32 signed  broadcast value
- cdb_dest_out  output  32 signed  broadcast destination/target

## Operation
- Per unit k: FIFO of FIFO_DEPTH entries {rob_ix, value, dest}, head/tail pointers wrap mod FIFO_DEPTH, count 0..FIFO_DEPTH.
- fu_stall_out[k] = (count[k] == FIFO_DEPTH), from registered count only; no combinational path from any input.
- Push: fu_valid_in[k] && !fu_stall_out[k] && !flush_in → entry written at tail, tail+1, count+1.
- Push is refused when full even if the same unit's head pops that cycle. The unit must hold its result while stalled.
- Arbitration (combinational over FIFO heads): candidates = units with count>0. Search order starts at rr_ptr, ascending, wraps at NUM_FU. The first candidate wins.
- Pop: if any candidate and !flush_in → winner's head entry registered onto cdb_*_out, cdb_valid_out<=1, winner head+1, count−1, rr_ptr <= (winner+1) mod NUM_FU.
- No candidate → cdb_valid_out<=0; cdb data outputs hold last values; rr_ptr unchanged.
- Simultaneous push and pop on the same non-full unit: count unchanged, both pointers advance.
- Only entries already in a FIFO at the clock edge compete. A result arriving this cycle cannot be broadcast this cycle (no bypass).
- flush_in=1 at an edge: all counts, heads and tails <= 0; cdb_valid_out<=0; inputs that cycle dropped; rr_ptr unchanged; cdb data outputs hold.
- ROB indices are not checked; duplicates are broadcast as presented.

## Timing
- Reset (rst_in=0, immediate, independent of clock): cdb_valid_out=0, cdb_rob_ix_out=0, cdb_value_out=0, cdb_dest_out=0, all counts/pointers 0, rr_ptr=0, fu_stall_out=all 0.
- Reset asserted mid-operation discards all buffered results. The first push is accepted at the first rising edge after rst_in returns to 1.
- Latency: result sampled at edge E0 → earliest CDB broadcast visible after edge E1, held for exactly one cycle (cdb_valid_out is a one-cycle pulse per result).
- Throughput: one broadcast per cycle total. With all units continuously offering, each unit gets one slot every NUM_FU cycles.
- fu_stall_out[k] rises the cycle after the push that fills the FIFO, and falls the cycle after the pop that frees a slot.
- Consumers sample cdb_*_out on the same edge they sample cdb_valid_out; data is stable for the whole cycle.

## Test plan
- Reset: drive rst_in=0 mid-cycle with results buffered → all outputs 0 immediately. Release, then push unit 1 {rob 5, value 0x1234, dest 0} at E0 → cdb_valid_out=1, rob_ix=5, value=0x1234 after E1 only, then 0.
- Round-robin: all 3 units push at the same edge (rob 1,2,3), rr_ptr=0 → broadcasts rob 1,2,3 on three consecutive cycles. Then push units 0 and 2 together (rr_ptr=0) → order 0 then 2.
- Back-pressure: unit 0 offers rob 0..3 on four consecutive cycles while units 1 and 2 are kept continuously busy with results. fu_stall_out[0] asserts when count=2. The held offer is accepted once a slot frees; broadcast order for unit 0 is 0,1,2,3 with none lost or duplicated.
- Full + pop same cycle: unit 2 FIFO full and winning arbitration while offering rob 7 → pop happens, push refused, stall deasserts next cycle, rob 7 accepted the following edge.
- Flush: 2 results buffered in unit 1, assert flush_in for one cycle while unit 0 offers rob 4 → no broadcast of any of them, cdb_valid_out=0, all stalls 0. A new push afterwards is broadcast normally.
- Idle: no valids for 10 cycles → cdb_valid_out stays 0, data outputs hold last broadcast values.
